// File: rtl/mdu_div.sv
// mdu_div: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, one operation in flight, result handed to the
// register-file write port through a DONE/ready handshake.
// Optional build macro: DIV_FAST_SPECIAL_EN -- when defined, divide-by-zero
// and signed overflow skip the iteration and go straight from IDLE to DONE.
module mdu_div #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  input  logic            kill_i,
  input  logic            wb_ready_i,
  output logic            busy_o,
  output logic            wb_en_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;

  logic            r_opRem;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_dvd;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_rem;
  logic [4:0]      r_count;
  logic            r_negQ;
  logic            r_negR;
  logic [XLEN-1:0] r_wbData;

  logic            w_signedOp;
  logic            w_sign1;
  logic            w_sign2;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic            w_div0;
  logic            w_accept;
  logic            w_special;
  logic [XLEN-1:0] w_specialData;

  logic [XLEN:0]   w_remShift;
  logic [XLEN:0]   w_diff;
  logic            w_qbit;
  logic [XLEN-1:0] w_remNext;
  logic [XLEN-1:0] w_quoNext;
  logic [XLEN-1:0] w_quoFinal;
  logic [XLEN-1:0] w_remFinal;
  logic [XLEN-1:0] w_result;

  // Operand conditioning: signed ops iterate on magnitudes and fix signs at the end.
  assign w_signedOp = ~op_i[0];
  assign w_sign1    = w_signedOp & rs1_data_i[XLEN-1];
  assign w_sign2    = w_signedOp & rs2_data_i[XLEN-1];
  assign w_abs1     = w_sign1 ? (~rs1_data_i + 1'b1) : rs1_data_i;
  assign w_abs2     = w_sign2 ? (~rs2_data_i + 1'b1) : rs2_data_i;
  assign w_div0     = (rs2_data_i == '0);
  assign w_accept   = (r_state == S_IDLE) && start_i && !kill_i;

`ifdef DIV_FAST_SPECIAL_EN
  logic w_ovf;
  // Signed overflow only exists for DIV/REM: most negative value divided by -1.
  assign w_ovf = w_signedOp && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (rs2_data_i == '1);
  assign w_special = w_div0 | w_ovf;
  // Architectural results for the shortcut cases, taken from the raw operands.
  assign w_specialData = op_i[1] ? (w_div0 ? rs1_data_i : '0)
                                 : (w_div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}});
`else
  assign w_special     = 1'b0;
  assign w_specialData = '0;
`endif

  // One restoring step: shift the next dividend bit into the partial
  // remainder, trial-subtract the divisor with a 33-bit borrow, keep or restore.
  assign w_remShift = {r_rem, r_dvd[XLEN-1]};
  assign w_diff     = w_remShift - {1'b0, r_dvs};
  assign w_qbit     = ~w_diff[XLEN];
  assign w_remNext  = w_qbit ? w_diff[XLEN-1:0] : w_remShift[XLEN-1:0];
  assign w_quoNext  = {r_dvd[XLEN-2:0], w_qbit};

  // Final sign fix and quotient/remainder selection for the last step.
  assign w_quoFinal = r_negQ ? (~w_quoNext + 1'b1) : w_quoNext;
  assign w_remFinal = r_negR ? (~w_remNext + 1'b1) : w_remNext;
  assign w_result   = r_opRem ? w_remFinal : w_quoFinal;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic; kill wins over start and over the write-back grant.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i && !kill_i) begin
          w_stateNext = w_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (kill_i) begin
          w_stateNext = S_IDLE;
        end else if (r_count == 5'd0) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        if (kill_i || wb_ready_i) begin
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC, capture the result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_opRem  <= 1'b0;
      r_rd     <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_count  <= '0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_wbData <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_opRem <= op_i[1];
            r_rd    <= rd_i;
            r_dvd   <= w_abs1;
            r_dvs   <= w_abs2;
            r_rem   <= '0;
            r_count <= 5'd31;
            r_negQ  <= (w_sign1 ^ w_sign2) & ~w_div0;
            r_negR  <= w_sign1;
            if (w_special) begin
              r_wbData <= w_specialData;
            end
          end
        end
        S_CALC: begin
          if (!kill_i) begin
            r_rem   <= w_remNext;
            r_dvd   <= w_quoNext;
            r_count <= r_count - 5'd1;
            if (r_count == 5'd0) begin
              r_wbData <= w_result;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_o    = (r_state != S_IDLE);
  assign wb_en_o   = (r_state == S_DONE);
  assign wb_rd_o   = r_rd;
  assign wb_data_o = r_wbData;

endmodule

// File: doc/mdu_div.md
# mdu_div

Iterative 32-bit divider implementing the RV32M DIV, DIVU, REM and REMU instructions.
- Consumes the two source operands read from the register file's read ports.
- Produces a register write-back (data, destination index, write enable) that drives the register file's write port through the write-back mux.
- Uses a radix-2 restoring algorithm: one quotient bit per cycle, one operation in flight.

## Interface
Parameters:
- XLEN, 32, operand and result width; only 32 is supported.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  request a new operation; accepted only in IDLE.
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i.
- rs1_data_i  in  32  dividend (register file read port 1); sampled with start_i.
- rs2_data_i  in  32  divisor (register file read port 2); sampled with start_i.
- rd_i  in  5  destination register index; sampled with start_i.
- kill_i  in  1  pipeline flush; aborts any operation in progress.
- wb_ready_i  in  1  write-back port grants this unit the register file write port this cycle.
- busy_o  out  1  high in CALC and DONE.
- wb_en_o  out  1  write enable to the register file; high in DONE.
- wb_rd_o  out  5  destination index for the write.
- wb_data_o  out  32  result to write.

## Operation
State machine: IDLE, CALC, DONE.

IDLE:
- If start_i=1 and kill_i=0, latch op_i and rd_i.
- For signed ops, latch |rs1| and |rs2|, plus neg_q = sign1 XOR sign2 and neg_r = sign1. For unsigned ops, latch the raw values.
- Clear the remainder register, load count=31, go to CALC.

CALC, each cycle:
- rem' = {rem[30:0], dvd[31]}.
- If rem' ≥ divisor (unsigned 33-bit compare), subtract the divisor and shift in quotient bit 1; otherwise keep rem' and shift in 0.
- Decrement count. On the cycle that count=0 completes, go to DONE.

Result formation, registered into wb_data_o on entry to DONE:
- DIV/DIVU select the quotient; REM/REMU select the remainder.
- Signed ops apply two's-complement negation when neg_q (quotient) or neg_r (remainder) is set.

Special cases (results mandatory, independent of configuration):
- Divisor 0: quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = dividend unmodified. The quotient sign fix is suppressed.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.

DONE:
- wb_en_o=1; wb_rd_o and wb_data_o are held stable.
- When wb_ready_i=1, the write occurs this cycle and the state returns to IDLE next edge.
- rd=0 is still written; the register file discards writes to x0.

Other rules:
- kill_i=1 in any state: next state IDLE, and no wb_en_o pulse is produced for the killed op. kill_i has priority over start_i and over wb_ready_i.
- start_i while busy_o=1 is ignored; it is not queued.

## Timing
Reset values:
- State IDLE.
- busy_o=0, wb_en_o=0, wb_rd_o=0, wb_data_o=0.
- All internal registers cleared.

Latency:
- Start accepted at edge E0.
- CALC occupies the cycles after E0 through E32.
- DONE is entered after E32, so wb_en_o is first high in the 33rd cycle after acceptance.
- Retirement happens at the first edge where wb_ready_i=1.
- With no backpressure: 34 cycles from accept to the next accept possible.

Other timing rules:
- busy_o rises the cycle after E0 and falls the cycle after retirement or kill.
- wb_en_o is a pure state decode: no combinational path from any input to any output.
- rst_i mid-operation: next edge gives IDLE with all outputs at reset values; no write-back.
- The same-cycle case wb_ready_i=1 with kill_i=1 resolves as a kill; no write occurs.

## Configuration
- DIV_FAST_SPECIAL_EN defined:
  - In IDLE, a divisor of 0 or the signed-overflow pattern is detected on the raw inputs.
  - The unit goes straight IDLE→DONE with the special-case result.
  - wb_en_o is high in the first cycle after E0, giving 2-cycle occupancy.
- DIV_FAST_SPECIAL_EN undefined:
  - Special cases run the full 32 CALC cycles with the normal latency.
  - Results are still exactly as specified under Operation.

## Test plan
- DIVU 100/7, wb_ready_i=1, rd=5: wb_en_o high 33 cycles after accept, wb_rd_o=5, wb_data_o=14; REMU of the same operands gives 2.
- DIV -7/2 gives 0xFFFFFFFD (-3); REM -7/2 gives 0xFFFFFFFF (-1); REM 7/-2 gives 1.
- DIV 5/0 gives 0xFFFFFFFF; REM 5/0 gives 5; DIV 0x80000000/0xFFFFFFFF gives 0x80000000 and REM gives 0. Run once with DIV_FAST_SPECIAL_EN defined and once without; required latency is 1 cycle with it and 33 cycles without.
- Backpressure: hold wb_ready_i=0 for 5 cycles in DONE. Required: wb_en_o stays high, data and rd stay stable, exactly one write occurs when wb_ready_i rises. A start_i pulsed during this window is ignored.
- kill_i at the 10th CALC cycle: busy_o=0 next cycle, wb_en_o never asserted; a start with DIVU 9/3 two cycles later returns 3.
- rst_i at the 20th CALC cycle: outputs are 0 next cycle and no write-back occurs; a subsequent op completes normally.
